hilo_multu: RTL and testbench
=============================

# hilo_multu

Iterative unsigned multiplier with architectural HI/LO registers for the single-cycle MIPS datapath. Sits directly downstream of the auxiliary decoder and consumes its HI/LO write enable and HI/LO read select. It executes MULTU over several cycles while holding the PC via `stall`, then drives the selected HI or LO value back toward the register-file write-back mux for MFHI/MFLO.

## Interface
- `WIDTH`, default 32. Operand width. Must be even. Product width is 2×WIDTH.

- `clk`  in  1  Rising-edge clock.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `start`  in  1  MULTU request, driven by the decoder's HI_en & LO_en. Held high for as long as MULTU is the fetched instruction.
- `hilo_sel`  in  1  Read select: 0 selects HI (MFHI), 1 selects LO (MFLO).
- `a`  in  WIDTH  Multiplicand, from rs read data.
- `b`  in  WIDTH  Multiplier, from rt read data.
- `stall`  out  1  Hold the PC and block register-file/DM writes while high.
- `done`  out  1  One-cycle pulse in the cycle after HI/LO update.
- `hi`  out  WIDTH  HI register. Upper half of the last product.
- `lo`  out  WIDTH  LO register. Lower half of the last product.
- `hilo_out`  out  WIDTH  Combinational output: `hilo_sel ? lo : hi`.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - When `start`=1 at a rising edge:
    - Capture `a` into the multiplicand register.
    - Capture `b` into the multiplier register.
    - Clear the WIDTH-bit accumulator.
    - Load the iteration counter with WIDTH, or WIDTH/2 when radix-4 is enabled.
    - Go to RUN.
- **RUN**, one iteration per cycle (radix-2):
  - If multiplier[0]=1, form `sum = {1'b0,acc} + {1'b0,mcand}`, which is WIDTH+1 bits. Otherwise `sum = {1'b0,acc}`.
  - Shift right: `{acc, mplier} <= {sum, mplier[WIDTH-1:1]}`.
  - Decrement the counter.
  - On the iteration where the counter reaches 0:
    - Load `hi` from the final acc and `lo` from the final mplier (the same values the shift would produce).
    - Go to DONE.
- **DONE**
  - `done`=1, `stall`=0.
  - `start` is ignored: the same MULTU is still fetched this cycle and must not retrigger.
  - Unconditionally go to IDLE.
- `stall = (state==IDLE && start) || state==RUN`. It is combinational, so the PC is held in the same cycle MULTU is decoded.
- Operand inputs are sampled only at the IDLE→RUN edge. Changes on `a`/`b` during RUN or DONE have no effect.
- `hi`/`lo` keep their previous values throughout RUN. They change only at the RUN→DONE edge or on reset.
- `hilo_out` follows `hilo_sel` combinationally in every state.
- Arithmetic is purely unsigned. The result is modulo 2^(2×WIDTH), i.e. the exact product with no overflow possible.

## Timing
- Reset (`rst_n`=0, asynchronous), regardless of state, including mid-RUN:
  - state=IDLE, `hi`=0, `lo`=0, `done`=0, counter=0.
  - `stall` then equals `start`.
  - An aborted multiply leaves no partial result in HI/LO.
- Latency, radix-2: `start` is sampled at edge E0, and HI/LO update at edge E0+WIDTH.
  - `stall` is high for exactly WIDTH+1 cycles: 1 IDLE cycle plus WIDTH RUN cycles. That is 33 cycles at WIDTH=32.
  - `done` is high during the cycle following E0+WIDTH.
- MFHI/MFLO issued in the cycle after DONE read the new product through `hilo_out`.
- Back-to-back MULTU: the second `start` is accepted in the IDLE cycle that immediately follows DONE.

## Configuration
- Macro: `HILO_MULTU_RADIX4_EN`.
- **Defined:** two multiplier bits are retired per RUN cycle.
  - The partial-product adder selects 0, mcand, 2·mcand or 3·mcand and is WIDTH+2 bits wide.
  - The shift is by 2.
  - RUN lasts WIDTH/2 cycles, so `stall` is high for WIDTH/2+1 cycles (17 at WIDTH=32).
- **Undefined:** the radix-2 behaviour above.
- Results, the reset behaviour and the DONE/`start`-ignore rules are identical in both builds.

## Test plan
- **Reset:** assert `rst_n`=0 with `start`=0 → `hi`=`lo`=0, `done`=0, `stall`=0. Then `hilo_sel`=0/1 → `hilo_out`=0.
- **Small product:** `a`=7, `b`=6, `start` held high → `stall` high for 33 cycles (17 with radix-4), then `lo`=0x0000002A, `hi`=0, one `done` pulse. With `hilo_sel`=1, `hilo_out`=0x2A.
- **Max operands:** `a`=`b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **Operand change mid-run:** `a`=0x10000, `b`=0x10000, then change `a`/`b` to random values one cycle after the accepting edge → `hi`=1, `lo`=0.
- **Reset mid-run:** pulse `rst_n` low during the 10th RUN cycle of 0x12345678×0x9 → `hi`=`lo`=0, state is IDLE. With `start` still high, a new multiply begins and completes with `lo`=0xA3D70A38, `hi`=0.
- **No retrigger, then back-to-back:** `start` held through DONE → exactly one multiply and one `done` pulse. Then `start` dropped for 1 cycle and reasserted with `a`=3, `b`=5 → second multiply accepted, `lo`=15.

Source files
------------

// File: rtl/hilo_multu.sv
// Iterative unsigned multiplier with architectural HI/LO registers (MULTU/MFHI/MFLO).
// Define HILO_MULTU_RADIX4_EN to retire two multiplier bits per RUN cycle instead of one.
module hilo_multu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hilo_out,
    output logic [1:0]       state_dbg
);

    // Handshake: start is a level request from the decoder; it is accepted only in IDLE,
    // stall stays high until the product is in HI/LO, and start seen in DONE is ignored.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] mplier_nx;
    logic [CW-1:0]    cnt;
    logic             last_iter;

`ifdef HILO_MULTU_RADIX4_EN
    localparam int ITERS = WIDTH / 2;

    logic [WIDTH+1:0] pp;
    logic [WIDTH+1:0] sum;

    always_comb begin
        case (mplier[1:0])
            2'd0:    pp = '0;
            2'd1:    pp = {2'b00, mcand};
            2'd2:    pp = {1'b0, mcand, 1'b0};
            default: pp = {2'b00, mcand} + {1'b0, mcand, 1'b0};
        endcase
        sum       = {2'b00, acc} + pp;
        acc_nx    = sum[WIDTH+1:2];
        mplier_nx = {sum[1:0], mplier[WIDTH-1:2]};
    end
`else
    localparam int ITERS = WIDTH;

    logic [WIDTH:0] sum;

    always_comb begin
        sum       = mplier[0] ? ({1'b0, acc} + {1'b0, mcand}) : {1'b0, acc};
        acc_nx    = sum[WIDTH:1];
        mplier_nx = {sum[0], mplier[WIDTH-1:1]};
    end
`endif

    assign last_iter = (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_iter) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // HI/LO are written only on the final iteration, so an aborted run leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= CW'(ITERS);
                    end
                end
                RUN: begin
                    acc    <= acc_nx;
                    mplier <= mplier_nx;
                    cnt    <= cnt - CW'(1);
                    if (last_iter) begin
                        hi <= acc_nx;
                        lo <= mplier_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall     = ((state == IDLE) && start) || (state == RUN);
    assign done      = (state == DONE);
    assign hilo_out  = hilo_sel ? lo : hi;
    assign state_dbg = state;

endmodule

// File: tb/tb_hilo_multu.sv
// Self-checking bench for hilo_multu: vector table, random products against an
// arithmetic reference, and hand-written reset/retrigger/back-to-back sequences.
module tb_hilo_multu;

    localparam int W = 32;
`ifdef HILO_MULTU_RADIX4_EN
    localparam int RUN_CYC = W / 2;
`else
    localparam int RUN_CYC = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         hilo_sel;
    logic [W-1:0] a, b;
    logic         stall, done;
    logic [W-1:0] hi, lo, hilo_out;
    logic [1:0]   state_dbg;

    int n_chk  = 0;
    int n_pass = 0;

    hilo_multu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .hilo_sel  (hilo_sel),
        .a         (a),
        .b         (b),
        .stall     (stall),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .hilo_out  (hilo_out),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           chg_cyc;
        int           rst_cyc;
        logic [W-1:0] e_hi;
        logic [W-1:0] e_lo;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] xx, yy;
        xx = {{W{1'b0}}, x};
        yy = {{W{1'b0}}, y};
        return xx * yy;
    endfunction

    task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Drives one MULTU with start held high; returns while sampling the DONE cycle.
    task automatic mul_seq(input logic [W-1:0] x, input logic [W-1:0] y, input int chg_cyc,
                           input int rst_cyc, input logic [W-1:0] e_hi,
                           input logic [W-1:0] e_lo, input string nm);
        int             st_cnt = 0;
        bit             seen   = 1'b0;
        bit             held   = 1'b1;
        logic [2*W-1:0] prev;
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        prev  = {hi, lo};
        for (int c = 0; c < 300 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            if (c == chg_cyc) begin
                a = $urandom;
                b = $urandom;
            end
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                chk({nm, " rst hi"}, 64'(hi), 64'd0);
                chk({nm, " rst lo"}, 64'(lo), 64'd0);
                chk({nm, " rst done"}, 64'(done), 64'd0);
                chk({nm, " rst stall"}, 64'(stall), 64'd1);
                chk({nm, " rst state"}, 64'(state_dbg), 64'd0);
                rst_n  = 1'b1;
                st_cnt = 0;
                prev   = '0;
            end
            #1;
            if (stall) st_cnt++;
            if (done) seen = 1'b1;
            else if ({hi, lo} !== prev) held = 1'b0;
        end
        chk({nm, " done seen"}, 64'(seen), 64'd1);
        chk({nm, " stall cycles"}, 64'(st_cnt), 64'(RUN_CYC + 1));
        chk({nm, " hilo held"}, 64'(held), 64'd1);
        chk({nm, " hi"}, 64'(hi), 64'(e_hi));
        chk({nm, " lo"}, 64'(lo), 64'(e_lo));
        hilo_sel = 1'b0;
        #1 chk({nm, " mfhi"}, 64'(hilo_out), 64'(e_hi));
        hilo_sel = 1'b1;
        #1 chk({nm, " mflo"}, 64'(hilo_out), 64'(e_lo));
    endtask

    // First cycle after DONE with start dropped: no retrigger, done was a single pulse.
    task automatic drop_chk(input string nm, input logic [W-1:0] e_hi, input logic [W-1:0] e_lo);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({nm, " no retrigger"}, 64'(stall), 64'd0);
        chk({nm, " done pulse"}, 64'(done), 64'd0);
        chk({nm, " result kept"}, {hi, lo}, {e_hi, e_lo});
    endtask

    initial begin
        logic [W-1:0]   x, y;
        logic [2*W-1:0] p;

        rst_n    = 1'b0;
        start    = 1'b0;
        hilo_sel = 1'b0;
        a        = '0;
        b        = '0;

        vecs[0] = '{32'd7,          32'd6,          -1, -1, 32'd0,          32'h0000_002A};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  -1, -1, 32'hFFFF_FFFE,  32'h0000_0001};
        vecs[2] = '{32'h0001_0000,  32'h0001_0000,   1, -1, 32'd1,          32'd0};
        vecs[3] = '{32'h1234_5678,  32'd9,          -1, 10, 32'd0,          32'hA3D7_0A38};
        vecs[4] = '{32'd0,          32'hFFFF_FFFF,  -1, -1, 32'd0,          32'd0};

        repeat (2) @(negedge clk);
        #1;
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset stall", 64'(stall), 64'd0);
        chk("reset state", 64'(state_dbg), 64'd0);
        hilo_sel = 1'b0;
        #1 chk("reset mfhi", 64'(hilo_out), 64'd0);
        hilo_sel = 1'b1;
        #1 chk("reset mflo", 64'(hilo_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            mul_seq(vecs[i].a, vecs[i].b, vecs[i].chg_cyc, vecs[i].rst_cyc,
                    vecs[i].e_hi, vecs[i].e_lo, $sformatf("vec%0d", i));
            drop_chk($sformatf("vec%0d", i), vecs[i].e_hi, vecs[i].e_lo);
        end

        for (int i = 0; i < 8; i++) begin
            x = (i < 4) ? W'($urandom) : W'($urandom_range(0, 65535));
            y = W'($urandom);
            p = ref_mul(x, y);
            mul_seq(x, y, (i % 2 == 0) ? 2 : -1, -1, p[2*W-1:W], p[W-1:0],
                    $sformatf("rand%0d", i));
            drop_chk($sformatf("rand%0d", i), p[2*W-1:W], p[W-1:0]);
        end

        // Back-to-back: second start is already high in the IDLE cycle right after DONE.
        x = 32'hDEAD_BEEF;
        y = 32'h0BAD_F00D;
        p = ref_mul(x, y);
        mul_seq(x, y, -1, -1, p[2*W-1:W], p[W-1:0], "b2b first");
        p = ref_mul(32'd3, 32'd5);
        mul_seq(32'd3, 32'd5, -1, -1, p[2*W-1:W], p[W-1:0], "b2b second");
        drop_chk("b2b second", 32'd0, 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
